// File: rtl/sqrt_sequencer.sv
// Multi-cycle integer square root: steps the non-restoring recurrence ITERS_PER_CYCLE
// stages per clock, then corrects the remainder and holds the result for a valid/ready consumer.
module sqrt_sequencer #(
    parameter int N               = 16,
    parameter int ITERS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_num,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N/2-1:0] out_root,
    output logic [N/2:0]   out_rem,
    output logic           busy
);

    localparam int H  = N / 2;
    localparam int RW = H + 2;
    localparam int CW = $clog2(H + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic                  last_step;

    logic [N-1:0]          a, a_nx;
    logic [H-1:0]          q, q_nx;
    logic signed [RW-1:0]  r, r_nx;

    // One recurrence stage: shift in the next radicand bit pair, then add or subtract
    // the trial term depending on the sign of the running remainder.
    function automatic logic signed [RW-1:0] next_rem(input logic signed [RW-1:0] r_i,
                                                      input logic [H-1:0]         q_i,
                                                      input logic [1:0]           top);
        logic signed [RW-1:0] left;
        logic signed [RW-1:0] right;
        left  = {r_i[H-1:0], top};
        right = {q_i, (r_i[RW-1] ? 2'b11 : 2'b01)};
        return r_i[RW-1] ? (left + right) : (left - right);
    endfunction

    // A negative final remainder overshot by one trial term; add 2q+1 back.
    function automatic logic [H:0] fix_rem(input logic signed [RW-1:0] r_i,
                                           input logic [H-1:0]         q_i);
        logic signed [RW-1:0] corr;
        logic signed [RW-1:0] res;
        corr = RW'({q_i, 1'b1});
        res  = r_i[RW-1] ? (r_i + corr) : r_i;
        return res[H:0];
    endfunction

    always_comb begin
        a_nx = a;
        q_nx = q;
        r_nx = r;
        for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
            r_nx = next_rem(r_nx, q_nx, a_nx[N-1:N-2]);
            q_nx = {q_nx[H-2:0], ~r_nx[RW-1]};
            a_nx = a_nx << 2;
        end
    end

    assign last_step = (cnt == CW'(H - ITERS_PER_CYCLE));

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = RUN;
            end
            RUN:  if (last_step) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            out_root <= '0;
            out_rem  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + CW'(ITERS_PER_CYCLE);
            if (state == FIX) begin
                out_root <= q;
                out_rem  <= fix_rem(r, q);
            end
        end
    end

    // Datapath registers carry no reset; the FSM decides when their contents matter.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a <= in_num;
            q <= '0;
            r <= '0;
        end else if (state == RUN) begin
            a <= a_nx;
            q <= q_nx;
            r <= r_nx;
        end
    end

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Bench for sqrt_sequencer: a 16-bit single-stage engine for directed cases and a
// 32-bit four-stage engine for randomized operands, both checked against an arithmetic model.
module tb_sqrt_sequencer;

    logic clk = 1'b0;
    logic rst;

    logic        v16, r16, ov16, ordy16, busy16;
    logic [15:0] n16;
    logic [7:0]  root16;
    logic [8:0]  rem16;

    logic        v32, r32, ov32, ordy32, busy32;
    logic [31:0] n32;
    logic [15:0] root32;
    logic [16:0] rem32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sqrt_sequencer #(.N(16), .ITERS_PER_CYCLE(1)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(v16), .in_ready(r16), .in_num(n16),
        .out_valid(ov16), .out_ready(ordy16),
        .out_root(root16), .out_rem(rem16), .busy(busy16)
    );

    sqrt_sequencer #(.N(32), .ITERS_PER_CYCLE(4)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(v32), .in_ready(r32), .in_num(n32),
        .out_valid(ov32), .out_ready(ordy32),
        .out_root(root32), .out_rem(rem32), .busy(busy32)
    );

    // Largest integer whose square does not exceed n, found by bitwise search.
    function automatic longint unsigned ref_root(input longint unsigned n, input int hb);
        longint unsigned res;
        longint unsigned t;
        res = 0;
        for (int b = hb - 1; b >= 0; b--) begin
            t = res | (64'd1 << b);
            if (t * t <= n) res = t;
        end
        return res;
    endfunction

    task automatic op16(input logic [15:0] n, input int stall);
        longint unsigned nn, rr;
        logic [7:0] er, hr;
        logic [8:0] em, hm;
        int lat;
        nn = n;
        rr = ref_root(nn, 8);
        er = rr[7:0];
        em = 9'(nn - rr * rr);
        total++;
        if (r16 !== 1'b1) begin bad++; $display("FAIL ready16_idle got=%b want=1", r16); end
        v16 = 1'b1; n16 = n;
        @(posedge clk); #1;
        v16 = 1'b0; n16 = 16'($urandom);
        lat = 0;
        while (ov16 !== 1'b1 && lat < 40) begin
            total++;
            if (r16 !== 1'b0 || busy16 !== 1'b1) begin
                bad++; $display("FAIL busy16 in_ready=%b busy=%b want 0/1", r16, busy16);
            end
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat != 9) begin bad++; $display("FAIL latency16 n=%0d got=%0d want=9", n, lat); end
        total++;
        if (root16 !== er) begin bad++; $display("FAIL root16 n=%0d got=%0d want=%0d", n, root16, er); end
        total++;
        if (rem16 !== em) begin bad++; $display("FAIL rem16 n=%0d got=%0d want=%0d", n, rem16, em); end
        hr = er; hm = em;
        repeat (stall) begin
            @(posedge clk); #1;
            total++;
            if (ov16 !== 1'b1 || root16 !== hr || rem16 !== hm || r16 !== 1'b0) begin
                bad++;
                $display("FAIL stall16 ov=%b root=%0d rem=%0d rdy=%b want 1/%0d/%0d/0",
                         ov16, root16, rem16, r16, hr, hm);
            end
        end
        ordy16 = 1'b1;
        @(posedge clk); #1;
        ordy16 = 1'b0;
        total++;
        if (ov16 !== 1'b0 || r16 !== 1'b1) begin
            bad++; $display("FAIL handshake16 ov=%b rdy=%b want 0/1", ov16, r16);
        end
    endtask

    task automatic op32(input logic [31:0] n);
        longint unsigned nn, rr;
        logic [15:0] er;
        logic [16:0] em;
        int lat;
        nn = n;
        rr = ref_root(nn, 16);
        er = rr[15:0];
        em = 17'(nn - rr * rr);
        v32 = 1'b1; n32 = n;
        @(posedge clk); #1;
        lat = 0;
        while (ov32 !== 1'b1 && lat < 40) begin
            v32 = 1'($urandom_range(0, 1));
            n32 = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        v32 = 1'b0;
        total++;
        if (lat != 5) begin bad++; $display("FAIL latency32 n=%0d got=%0d want=5", n, lat); end
        total++;
        if (root32 !== er) begin bad++; $display("FAIL root32 n=%0d got=%0d want=%0d", n, root32, er); end
        total++;
        if (rem32 !== em) begin bad++; $display("FAIL rem32 n=%0d got=%0d want=%0d", n, rem32, em); end
        ordy32 = 1'b1;
        @(posedge clk); #1;
        ordy32 = 1'b0;
        total++;
        if (ov32 !== 1'b0 || r32 !== 1'b1) begin
            bad++; $display("FAIL handshake32 ov=%b rdy=%b want 0/1", ov32, r32);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (r16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0) begin
            bad++; $display("FAIL reset16_ctrl rdy=%b ov=%b busy=%b want 1/0/0", r16, ov16, busy16);
        end
        total++;
        if (root16 !== 8'd0 || rem16 !== 9'd0) begin
            bad++; $display("FAIL reset16_data root=%0d rem=%0d want 0/0", root16, rem16);
        end
        total++;
        if (r32 !== 1'b1 || ov32 !== 1'b0 || busy32 !== 1'b0) begin
            bad++; $display("FAIL reset32_ctrl rdy=%b ov=%b busy=%b want 1/0/0", r32, ov32, busy32);
        end
        total++;
        if (root32 !== 16'd0 || rem32 !== 17'd0) begin
            bad++; $display("FAIL reset32_data root=%0d rem=%0d want 0/0", root32, rem32);
        end
    endtask

    task automatic test_directed();
        op16(16'd0, 0);
        op16(16'd17, 0);
        op16(16'd144, 0);
        op16(16'hFFFF, 0);
        op16(16'd1, 0);
        op16(16'd3, 0);
    endtask

    task automatic test_stall();
        op16(16'd50000, 5);
    endtask

    task automatic test_reset_midop();
        v16 = 1'b1; n16 = 16'h4321;
        @(posedge clk); #1;
        v16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (r16 !== 1'b1 || busy16 !== 1'b0 || ov16 !== 1'b0) begin
            bad++; $display("FAIL abort16_ctrl rdy=%b busy=%b ov=%b want 1/0/0", r16, busy16, ov16);
        end
        total++;
        if (root16 !== 8'd0 || rem16 !== 9'd0) begin
            bad++; $display("FAIL abort16_clear root=%0d rem=%0d want 0/0", root16, rem16);
        end
        repeat (12) begin
            @(posedge clk); #1;
            total++;
            if (ov16 !== 1'b0) begin bad++; $display("FAIL abort16_novalid ov=%b want 0", ov16); end
        end
        op16(16'd100, 0);
    endtask

    task automatic test_random16();
        for (int i = 0; i < 20; i++) op16(16'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_random32();
        op32(32'd0);
        op32(32'hFFFF_FFFF);
        op32(32'hFFFE_0001);
        op32(32'hFFFE_0000);
        for (int i = 0; i < 3000; i++) op32($urandom);
    endtask

    initial begin
        v16 = 1'b0; n16 = '0; ordy16 = 1'b0;
        v32 = 1'b0; n32 = '0; ordy32 = 1'b0;
        rst = 1'b1;
        test_reset();
        test_directed();
        test_stall();
        test_reset_midop();
        test_random16();
        test_random32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
